iob_clint_tick_master: RTL

- Native-bus initiator that services the CLINT machine-timer interrupt in hardware, with no CPU involvement.
- When mtip rises, it reads the 64-bit mtime, computes the next deadline (mtime + period), and rewrites mtimecmp for one hart using the glitch-safe sequence.
- Drives the CLINT slave port through the same valid/address/wdata/wstrb/rdata/ready protocol, and emits a periodic tick pulse and a tick counter.

---
 rtl/iob_clint_tick_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/iob_clint_tick_master.sv
// iob_clint_tick_master: hardware re-arm of the CLINT machine timer over the native bus.
// Define IOB_CLINT_TICK_MSIP_EN to also clear msip in hardware and pulse swi_tick.
module iob_clint_tick_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int HART_ID = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [31:0]         period,
  input  logic                mtip,
  input  logic                msip,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready,
  output logic                busy,
  output logic                tick,
  output logic [31:0]         tick_cnt,
  output logic                swi_tick
);
  typedef enum logic [3:0] {
    IDLE, RD_HI1, RD_LO, RD_HI2, CALC, WR_MAX, WR_LO, WR_HI, DONE
`ifdef IOB_CLINT_TICK_MSIP_EN
    , WR_MSIP, SWI_DONE
`endif
  } state_t;
  localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(32'hBFF8);
  localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(32'hBFFC);
  localparam logic [ADDR_W-1:0] CMP_LO   = ADDR_W'(32'h4000 + 8 * HART_ID);
  localparam logic [ADDR_W-1:0] CMP_HI   = ADDR_W'(32'h4004 + 8 * HART_ID);
`ifdef IOB_CLINT_TICK_MSIP_EN
  localparam logic [ADDR_W-1:0] MSIP    = ADDR_W'(4 * HART_ID);
`else
  logic unused_msip;
  assign unused_msip = msip;
`endif
  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   hi1_q, hi1_d, lo_q, lo_d;
  logic [63:0]         next_q, next_d;
  logic [31:0]         tick_cnt_q, tick_cnt_d;
  logic                bus_req, bus_we, ack;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [31:0]         eff_period;
  assign ack        = valid_q && ready;
  assign eff_period = (period == 32'd0) ? 32'd1 : period;
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    hi1_d      = hi1_q;
    lo_d       = lo_q;
    next_d     = next_q;
    tick_cnt_d = tick_cnt_q;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (enable && mtip) state_d = RD_HI1;
`ifdef IOB_CLINT_TICK_MSIP_EN
        else if (enable && msip) state_d = WR_MSIP;
`endif
      end
      RD_HI1: begin
        bus_req  = 1'b1;
        bus_addr = MTIME_HI;
        if (ack) begin
          hi1_d   = rdata;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        bus_req  = 1'b1;
        bus_addr = MTIME_LO;
        if (ack) begin
          lo_d    = rdata;
          state_d = RD_HI2;
        end
      end
      RD_HI2: begin
        bus_req  = 1'b1;
        bus_addr = MTIME_HI;
        // A changed high word means the low word rolled over between reads
        if (ack) begin
          hi1_d   = rdata;
          state_d = (rdata == hi1_q) ? CALC : RD_LO;
        end
      end
      CALC: begin
        next_d  = {hi1_q, lo_q} + {32'd0, eff_period};
        state_d = WR_MAX;
      end
      WR_MAX: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = CMP_HI;
        bus_wdata = '1;
        state_d   = ack ? WR_LO : WR_MAX;
      end
      WR_LO: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = CMP_LO;
        bus_wdata = next_q[31:0];
        state_d   = ack ? WR_HI : WR_LO;
      end
      WR_HI: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = CMP_HI;
        bus_wdata = next_q[63:32];
        state_d   = ack ? DONE : WR_HI;
      end
      DONE: begin
        tick_cnt_d = tick_cnt_q + 32'd1;
        state_d    = IDLE;
      end
`ifdef IOB_CLINT_TICK_MSIP_EN
      WR_MSIP: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = MSIP;
        state_d  = ack ? SWI_DONE : WR_MSIP;
      end
      SWI_DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // A request launches only from an idle bus, which guarantees the gap cycle
    if (bus_req && !valid_q) begin
      valid_d   = 1'b1;
      address_d = bus_addr;
      wdata_d   = bus_wdata;
      wstrb_d   = {(DATA_W/8){bus_we}};
    end
    if (ack) valid_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      hi1_q      <= '0;
      lo_q       <= '0;
      next_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      hi1_q      <= hi1_d;
      lo_q       <= lo_d;
      next_q     <= next_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end
  assign valid    = valid_q;
  assign address  = address_q;
  assign wdata    = wdata_q;
  assign wstrb    = wstrb_q;
  assign busy     = state_q != IDLE;
  assign tick     = state_q == DONE;
  assign tick_cnt = tick_cnt_q;
`ifdef IOB_CLINT_TICK_MSIP_EN
  assign swi_tick = state_q == SWI_DONE;
`else
  assign swi_tick = 1'b0;
`endif
endmodule
